// File: rtl/rx_uart_fifo_if.sv
// Receive-side bundle between rx_uart_fifo and the keyboard-style consumer.
// flag acts as valid and clear_flag as ready. The head entry (char0,
// parity_err, framing_err) stays stable while flag is high. An entry is
// consumed on the clock edge where both flag and clear_flag are high.
// A clear_flag while flag is low is ignored.
interface rx_uart_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 clear_flag;
  logic                 flag;
  logic [0:DATA_BITS-1] char0;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun;
  logic [2:0]           dbg_state;

  modport master (
    input  rx, clear_flag,
    output flag, char0, parity_err, framing_err, overrun, dbg_state
  );

  modport slave (
    output rx, clear_flag,
    input  flag, char0, parity_err, framing_err, overrun, dbg_state
  );
endinterface

// File: rtl/rx_uart_fifo.sv
// Oversampling serial receiver with a small holding FIFO for the PDP-8e
// console/aux ports. Character length, parity and oversampling are set by
// parameters. Define RX_MAJORITY_EN to make every bit decision a 2-of-3 vote
// of the ticks around mid-bit instead of a single mid-bit sample.
module rx_uart_fifo #(
  parameter int CLKS_PER_TICK = 27,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int FIFO_DEPTH    = 2
) (
  input logic            clk,
  input logic            reset,
  input logic            clear,
  rx_uart_fifo_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [14:0]   RELOAD    = 15'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] START_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] BIT_MID   = TW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
  // Decision lands one tick after mid; a bit's mid+1 is tcnt 0 of the next
  // period, so the count keeps running and bit timing is not disturbed.
  localparam logic [TW-1:0] START_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] BIT_DEC    = '0;
  localparam logic [TW-1:0] START_EXIT = TW'(1);
`else
  localparam logic [TW-1:0] START_DEC  = START_MID;
  localparam logic [TW-1:0] BIT_DEC    = BIT_MID;
  localparam logic [TW-1:0] START_EXIT = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic                 rst;
  logic                 rx_s1, rx_sync;
  logic [14:0]          tick_cnt;
  logic                 tick;
  logic                 samp;
  state_t               state_q, state_n;
  logic [TW-1:0]        tcnt_q, tcnt_n;
  logic [2:0]           idx_q, idx_n, pos;
  logic [0:DATA_BITS-1] char_q, char_n;
  logic                 perr_q, perr_n;
  logic                 push, stop_ferr;

  assign rst = reset | clear;

  // Two-flop synchroniser for the asynchronous line, idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= bus.rx;
      rx_sync <= rx_s1;
    end
  end

  // Free-running oversample tick generator.
  assign tick = (tick_cnt == '0);
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= RELOAD;
    else             tick_cnt <= tick_cnt - 1'b1;
  end

`ifdef RX_MAJORITY_EN
  logic          vote_early, vote_mid;
  logic [TW-1:0] mid_t;
  assign mid_t = (state_q == S_START) ? START_MID : BIT_MID;
  // Capture the line at mid-1 and mid; the third vote is the live line.
  always_ff @(posedge clk) begin
    if (rst) begin
      vote_early <= 1'b1;
      vote_mid   <= 1'b1;
    end else if (tick) begin
      if (tcnt_q == mid_t - 1'b1) vote_early <= rx_sync;
      if (tcnt_q == mid_t)        vote_mid   <= rx_sync;
    end
  end
  assign samp = (vote_early & vote_mid) | (vote_early & rx_sync) | (vote_mid & rx_sync);
`else
  assign samp = rx_sync;
`endif

  // First received bit lands at index DATA_BITS-1, the LSB position.
  assign pos = 3'(DATA_BITS - 1) - idx_q;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tcnt_q  <= tcnt_n;
      idx_q   <= idx_n;
      char_q  <= char_n;
      perr_q  <= perr_n;
    end
  end

  // Frame FSM next state; everything advances only on a tick.
  always_comb begin
    state_n   = state_q;
    tcnt_n    = tcnt_q;
    idx_n     = idx_q;
    char_n    = char_q;
    perr_n    = perr_q;
    push      = 1'b0;
    stop_ferr = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync) begin
            state_n = S_START;
            tcnt_n  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == START_DEC) begin
            if (samp) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              tcnt_n  = START_EXIT;
              idx_n   = '0;
              perr_n  = 1'b0;
            end
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
        S_DATA: begin
          tcnt_n = tcnt_q + 1'b1;
          if (tcnt_q == BIT_DEC) begin
            char_n[pos] = samp;
            if (idx_q == 3'(DATA_BITS - 1)) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            else                            idx_n = idx_q + 1'b1;
          end
        end
        S_PARITY: begin
          tcnt_n = tcnt_q + 1'b1;
          if (tcnt_q == BIT_DEC) begin
            perr_n  = (PARITY == 1) ? ~(^char_q ^ samp) : (^char_q ^ samp);
            state_n = S_STOP;
          end
        end
        S_STOP: begin
          tcnt_n = tcnt_q + 1'b1;
          if (tcnt_q == BIT_DEC) begin
            push      = 1'b1;
            stop_ferr = ~samp;
            state_n   = samp ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx_sync) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Holding FIFO with a registered head entry.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] push_entry, head_q;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic          full, empty, pop, push_ok, overrun_q;

  assign push_entry = {char_q, perr_q, stop_ferr};
  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = bus.clear_flag && !empty;
  assign push_ok    = push && (!full || pop);
  assign rd_ptr_n   = pop ? rd_ptr + 1'b1 : rd_ptr;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Storage array write port; pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy, sticky overrun and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
      head_q    <= {{DATA_BITS{1'b1}}, 2'b00};
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (push && full && !pop) overrun_q <= 1'b1;
      // Empty after this cycle: keep showing the last character.
      if (count_n != '0) begin
        if (push_ok && (rd_ptr_n == wr_ptr)) head_q <= push_entry;
        else                                 head_q <= mem[rd_ptr_n];
      end
    end
  end

  assign bus.flag        = !empty;
  assign bus.char0       = head_q[EW-1:2];
  assign bus.parity_err  = head_q[1];
  assign bus.framing_err = head_q[0];
  assign bus.overrun     = overrun_q;
  assign bus.dbg_state   = state_q;
endmodule
